dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage and one auxiliary requester
//  (loader/debug/DMA port). The pipeline has priority. The aux port is guaranteed service after
//  MAX_WAIT denied cycles; on that cycle the arbiter forces a one-cycle pipeline stall.
//  Sits between the EX/MEM register outputs, the MEM-store forward mux and the dataMemory instance.
//  The memory is clocked on ~clk, so read data (m_q) is valid in the same cycle as the request.
// PARAMETERS
//  ADDR_W    8   memory word-address width
//  DATA_W    32  data width
//  MAX_WAIT  4   denied aux cycles before a forced grant (1..15)
// PORTS
//  clk       in   1       system clock, rising edge
//  rst       in   1       synchronous reset, active-low
//  p_rden    in   1       pipeline MEM-stage read enable
//  p_wren    in   1       pipeline MEM-stage write enable
//  p_addr    in   ADDR_W  pipeline address
//  p_wdata   in   DATA_W  pipeline store data (already forwarded)
//  p_rdata   out  DATA_W  pipeline load data, to MEM/WB
//  p_stall   out  1       freeze PC, IF/ID, ID/EX and EX/MEM; flush MEM/WB this cycle
//  a_req     in   1       aux request; held until a_gnt
//  a_we      in   1       aux write (1) / read (0); valid with a_req
//  a_addr    in   ADDR_W  aux address
//  a_wdata   in   DATA_W  aux write data
//  a_gnt     out  1       aux access performed this cycle
//  a_rvalid  out  1       aux read data valid; one-cycle pulse
//  a_rdata   out  DATA_W  aux read data, registered
//  m_addr    out  ADDR_W  to dataMemory address
//  m_wdata   out  DATA_W  to dataMemory data
//  m_rden    out  1       to dataMemory rden
//  m_wren    out  1       to dataMemory wren
//  m_q       in   DATA_W  from dataMemory q
// BEHAVIOUR
//  - p_act = p_rden|p_wren. force = a_req & (wait_cnt==MAX_WAIT).
//  - Grant (combinational): a_gnt = a_req & (~p_act | force). Pipeline owns the port when p_act & ~a_gnt.
//  - p_stall = force & p_act. The pipeline re-presents the same access the next cycle.
//    The MEM-stage access is not performed in a stall cycle; its store must not occur then.
//  - Memory mux: a_gnt -> m_* = {a_addr, a_wdata, rden=~a_we, wren=a_we}.
//    Pipeline owner -> m_* = {p_addr, p_wdata, p_rden, p_wren}. Otherwise rden=wren=0, addr/data=0.
//  - p_rdata = m_q when the pipeline owns the port, else 0.
//  - wait_cnt (4b): 0 when a_gnt or ~a_req; else wait_cnt+1, saturating at MAX_WAIT.
//  - Aux read: on a granted read edge, a_rdata <= m_q and a_rvalid <= 1. Otherwise a_rvalid <= 0 and a_rdata holds.
//  - FSM view (wait_cnt): WAIT0..WAIT(MAX_WAIT-1) on denial -> next. WAITMAX grants unconditionally -> WAIT0.
//    Back-to-back forced grants are impossible, so the pipeline loses at most 1 of every MAX_WAIT+1 cycles.
//  - Aux write while pipeline is idle is a normal grant with no stall. Same-address writes are serialized:
//    the aux write (forced cycle) completes first, then the pipeline write.
//  - Reset (rst==0 at edge): wait_cnt=0, a_rvalid=0, a_rdata=0.
//    While rst==0: a_gnt=0, p_stall=0, m_rden=m_wren=0, p_rdata=0.
//    A granted aux read in flight is dropped; no a_rvalid after reset.
//  - p_rden&p_wren together: both enables are passed through unchanged. Illegal input; the bench flags it.
// TESTING
//  1 rst=0, a_req=1, p_wren=1, p_addr=0x05 -> m_wren=0, a_gnt=0, p_stall=0. After release, wait_cnt=0.
//  2 Pipeline idle, a_req=1, a_we=0, a_addr=0x10, mem[0x10]=0xDEADBEEF -> a_gnt=1 in cycle 0.
//    Cycle 1: a_rvalid=1, a_rdata=0xDEADBEEF. Cycle 2: a_rvalid=0.
//  3 MAX_WAIT=4; p_rden and a_req held high from cycle 0 -> cycles 0-3: a_gnt=0, m_addr=p_addr.
//    Cycle 4: a_gnt=1, p_stall=1, m_addr=a_addr. Cycle 5: pipeline served, p_stall=0.
//  4 Aux write 0x11111111 forced at addr 0x20 while pipeline writes 0x22222222 to 0x20
//    -> cycle N: aux write. Cycle N+1: pipeline write. Final mem[0x20]=0x22222222.
//  5 Granted aux read at cycle N, rst=0 at edge N+1 -> a_rvalid stays 0 and a_rdata=0.
//  6 Aux request withdrawn at wait_cnt=3 -> wait_cnt=0. A new request waits the full MAX_WAIT.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single-port data memory between the pipeline MEM stage and one
// auxiliary requester (loader / debug / DMA). The pipeline normally wins. An
// aux request that has been denied for MAX_WAIT consecutive cycles is granted
// unconditionally. If the pipeline also wants the memory on that cycle, it is
// stalled for that one cycle and re-presents its access on the next cycle.
//
// The memory is clocked on ~clk, so m_q is valid in the same cycle as the
// request. Because of this, grant and mux are purely combinational, and only
// the aux read data is registered.
//
// Parameters
//   ADDR_W    memory word-address width
//   DATA_W    data width
//   MAX_WAIT  denied aux cycles before a forced grant (1..15)
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous reset, active-low
//   p_rden    pipeline MEM-stage read enable
//   p_wren    pipeline MEM-stage write enable
//   p_addr    pipeline address
//   p_wdata   pipeline store data (already forwarded)
//   p_rdata   pipeline load data, to MEM/WB
//   p_stall   freeze PC, IF/ID, ID/EX, EX/MEM; flush MEM/WB this cycle
//   a_req     aux request, held until a_gnt
//   a_we      aux write (1) / read (0), valid with a_req
//   a_addr    aux address
//   a_wdata   aux write data
//   a_gnt     aux access performed this cycle
//   a_rvalid  aux read data valid, one-cycle pulse
//   a_rdata   aux read data, registered
//   m_addr    dataMemory address
//   m_wdata   dataMemory write data
//   m_rden    dataMemory read enable
//   m_wren    dataMemory write enable
//   m_q       dataMemory read data
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p_rden,
   input  logic              p_wren,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic [DATA_W-1:0] p_rdata,
   output logic              p_stall,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_rden,
   output logic              m_wren,
   input  logic [DATA_W-1:0] m_q
);

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   logic [3:0] wait_cnt;
   logic [3:0] wait_cnt_nxt;
   logic       p_act;
   logic       force_gnt;
   logic       p_own;

   // Arbitration. While reset is asserted nothing is granted and the pipeline
   // does not own the port, so no memory access can happen.
   always_comb begin
      p_act     = p_rden | p_wren;
      force_gnt = a_req & (wait_cnt == WAIT_MAX);
      a_gnt     = rst & a_req & (~p_act | force_gnt);
      // A forced grant takes the port away from the pipeline, which also
      // suppresses the stalled store for this cycle.
      p_own     = rst & p_act & ~a_gnt;
      p_stall   = rst & force_gnt & p_act;
   end

   // Memory port mux
   always_comb begin
      m_addr  = '0;
      m_wdata = '0;
      m_rden  = 1'b0;
      m_wren  = 1'b0;
      p_rdata = '0;
      if (a_gnt) begin
         m_addr  = a_addr;
         m_wdata = a_wdata;
         m_rden  = ~a_we;
         m_wren  = a_we;
      end else if (p_own) begin
         m_addr  = p_addr;
         m_wdata = p_wdata;
         m_rden  = p_rden;
         m_wren  = p_wren;
         p_rdata = m_q;
      end
   end

   // Wait counter next state. The counter never sits at WAIT_MAX for more
   // than one cycle, because a request there is always granted. This means
   // back-to-back forced stalls cannot occur.
   always_comb begin
      wait_cnt_nxt = wait_cnt;
      if (a_gnt | ~a_req) begin
         wait_cnt_nxt = 4'd0;
      end else if (wait_cnt != WAIT_MAX) begin
         wait_cnt_nxt = wait_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt <= 4'd0;
      end else begin
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // ---- stage boundary: aux read data captured at the end of the grant cycle
   // A read in flight when reset hits is dropped, and no a_rvalid follows it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_rvalid <= 1'b0;
         a_rdata  <= '0;
      end else if (a_gnt && !a_we) begin
         a_rvalid <= 1'b1;
         a_rdata  <= m_q;
      end else begin
         a_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed bench for dmem_port_arbiter. It includes a behavioural data memory
// clocked on the falling edge, so read data is valid within the request cycle.
// Inputs change 1 ns after the rising edge. Outputs are checked 7 ns after
// the rising edge, which is after the memory's falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              p_rden, p_wren;
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_wdata;
   logic [DATA_W-1:0] p_rdata;
   logic              p_stall;
   logic              a_req, a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_gnt, a_rvalid;
   logic [DATA_W-1:0] a_rdata;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_rden, m_wren;
   logic [DATA_W-1:0] m_q;

   logic [DATA_W-1:0] mem [0:255];

   int total  = 0;
   int passed = 0;
   int failed = 0;

   dmem_port_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .p_rden  (p_rden),
      .p_wren  (p_wren),
      .p_addr  (p_addr),
      .p_wdata (p_wdata),
      .p_rdata (p_rdata),
      .p_stall (p_stall),
      .a_req   (a_req),
      .a_we    (a_we),
      .a_addr  (a_addr),
      .a_wdata (a_wdata),
      .a_gnt   (a_gnt),
      .a_rvalid(a_rvalid),
      .a_rdata (a_rdata),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rden  (m_rden),
      .m_wren  (m_wren),
      .m_q     (m_q)
   );

   always #5 clk = ~clk;

   // Single-port memory on ~clk
   always @(negedge clk) begin
      if (m_wren) mem[m_addr] = m_wdata;
      if (m_rden) m_q = mem[m_addr];
   end

   always @(posedge clk) begin
      if (rst === 1'b1 && p_rden === 1'b1 && p_wren === 1'b1)
         $warning("illegal input: p_rden and p_wren both high at %0t", $time);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #6;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 32'hDEADBEEF;
      mem[8'h30] = 32'hCAFEF00D;
      m_q     = '0;
      rst     = 1'b0;
      p_rden  = 1'b0;
      p_wren  = 1'b0;
      p_addr  = '0;
      p_wdata = '0;
      a_req   = 1'b0;
      a_we    = 1'b0;
      a_addr  = '0;
      a_wdata = '0;

      // 1: reset blocks all access, even with both requesters active
      tick();
      rst = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 8'h30;
      p_wren = 1'b1; p_addr = 8'h05; p_wdata = 32'h12345678;
      settle();
      chk("rst_m_wren",  m_wren,  0);
      chk("rst_m_rden",  m_rden,  0);
      chk("rst_a_gnt",   a_gnt,   0);
      chk("rst_p_stall", p_stall, 0);
      chk("rst_p_rdata", p_rdata, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_a_rdata", a_rdata, 0);
      repeat (5) tick();
      chk("rst_no_store", mem[8'h05], 0);

      // 3 (also the post-reset wait_cnt=0 check): forced grant after MAX_WAIT
      rst = 1'b1; p_wren = 1'b0; p_rden = 1'b1; p_addr = 8'h10;
      for (int c = 0; c < MAX_WAIT; c++) begin
         settle();
         chk("force_deny_gnt",   a_gnt,   0);
         chk("force_deny_addr",  m_addr,  8'h10);
         chk("force_deny_stall", p_stall, 0);
         chk("force_deny_prd",   p_rdata, 32'hDEADBEEF);
         tick();
      end
      settle();
      chk("force_gnt",   a_gnt,   1);
      chk("force_stall", p_stall, 1);
      chk("force_addr",  m_addr,  8'h30);
      chk("force_rden",  m_rden,  1);
      chk("force_prd0",  p_rdata, 0);
      tick();
      a_req = 1'b0;
      settle();
      chk("force_rvalid",  a_rvalid, 1);
      chk("force_rdata",   a_rdata,  32'hCAFEF00D);
      chk("after_stall",   p_stall,  0);
      chk("after_gnt",     a_gnt,    0);
      chk("after_addr",    m_addr,   8'h10);
      chk("after_prd",     p_rdata,  32'hDEADBEEF);
      tick();
      p_rden = 1'b0;
      settle();
      chk("idle_rvalid", a_rvalid, 0);
      chk("idle_rden",   m_rden,   0);
      chk("idle_addr",   m_addr,   0);

      // 2: aux read with the pipeline idle is granted immediately
      tick();
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
      settle();
      chk("aux_rd_gnt",   a_gnt,   1);
      chk("aux_rd_rden",  m_rden,  1);
      chk("aux_rd_addr",  m_addr,  8'h10);
      chk("aux_rd_stall", p_stall, 0);
      tick();
      a_req = 1'b0;
      settle();
      chk("aux_rd_rvalid1", a_rvalid, 1);
      chk("aux_rd_rdata1",  a_rdata,  32'hDEADBEEF);
      chk("aux_rd_gnt1",    a_gnt,    0);
      tick();
      settle();
      chk("aux_rd_rvalid2", a_rvalid, 0);
      chk("aux_rd_rdata2",  a_rdata,  32'hDEADBEEF);

      // 4: same-address writes, the forced aux write goes first, then the pipeline
      tick();
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 32'h11111111;
      p_wren = 1'b1; p_addr = 8'h20; p_wdata = 32'h22222222;
      for (int c = 0; c < MAX_WAIT; c++) begin
         settle();
         chk("wr_deny_gnt",   a_gnt,   0);
         chk("wr_deny_wren",  m_wren,  1);
         chk("wr_deny_wdata", m_wdata, 32'h22222222);
         tick();
      end
      settle();
      chk("wr_force_gnt",   a_gnt,       1);
      chk("wr_force_stall", p_stall,     1);
      chk("wr_force_wdata", m_wdata,     32'h11111111);
      chk("wr_force_rden",  m_rden,      0);
      chk("wr_force_mem",   mem[8'h20],  32'h11111111);
      tick();
      a_req = 1'b0; a_we = 1'b0;
      settle();
      chk("wr_pipe_stall", p_stall,    0);
      chk("wr_pipe_wdata", m_wdata,    32'h22222222);
      chk("wr_pipe_mem",   mem[8'h20], 32'h22222222);
      tick();
      p_wren = 1'b0;
      settle();
      chk("wr_final_mem",  mem[8'h20], 32'h22222222);
      chk("wr_final_wren", m_wren,     0);
      chk("wr_no_rvalid",  a_rvalid,   0);

      // 5: reset at the edge that would return aux read data drops it
      tick();
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
      settle();
      chk("rstrd_gnt", a_gnt, 1);
      #1;
      rst = 1'b0;
      tick();
      a_req = 1'b0;
      settle();
      chk("rstrd_rvalid", a_rvalid, 0);
      chk("rstrd_rdata",  a_rdata,  0);
      tick();
      settle();
      chk("rstrd_rvalid2", a_rvalid, 0);
      tick();
      rst = 1'b1;

      // 6: withdrawing a request clears the wait count
      p_rden = 1'b1; p_addr = 8'h10; a_req = 1'b1; a_we = 1'b0; a_addr = 8'h30;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("wd_deny_gnt", a_gnt, 0);
         tick();
      end
      a_req = 1'b0;
      settle();
      chk("wd_off_gnt", a_gnt,   0);
      chk("wd_off_prd", p_rdata, 32'hDEADBEEF);
      tick();
      a_req = 1'b1;
      for (int c = 0; c < MAX_WAIT; c++) begin
         settle();
         chk("wd_rewait_gnt",   a_gnt,   0);
         chk("wd_rewait_stall", p_stall, 0);
         tick();
      end
      settle();
      chk("wd_force_gnt",   a_gnt,   1);
      chk("wd_force_stall", p_stall, 1);
      tick();
      a_req = 1'b0; p_rden = 1'b0;
      settle();
      chk("wd_rvalid", a_rvalid, 1);
      chk("wd_rdata",  a_rdata,  32'hCAFEF00D);
      chk("wd_stall",  p_stall,  0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
